// File: rtl/usb_xact_ctrl_pkg.sv
// usb_xact_ctrl_pkg: USB PIDs, transaction states and shared constants
package usb_xact_ctrl_pkg;
    typedef enum logic [3:0] {
        PID_OUT   = 4'h1,
        PID_IN    = 4'h9,
        PID_SOF   = 4'h5,
        PID_SETUP = 4'hD,
        PID_DATA0 = 4'h3,
        PID_DATA1 = 4'hB,
        PID_ACK   = 4'h2,
        PID_NACK  = 4'hA,
        PID_STALL = 4'hE
    } pid_t;

    typedef enum logic [2:0] {IDLE, RX_DATA, TX_HS, TX_DATA, WAIT_ACK} xact_state_t;

    // 18 low-speed bit times at 8 clk per bit
    localparam int USB_LS_TIMEOUT = 144;

    function automatic pid_t data_pid(input logic toggle);
        return toggle ? PID_DATA1 : PID_DATA0;
    endfunction
endpackage

// File: rtl/usb_xact_ctrl_if.sv
// usb_xact_ctrl_if: packet decoder/encoder and endpoint buffer signals of the transaction sequencer
interface usb_xact_ctrl_if #(parameter int N_EP = 2);
    logic            rx_tok_valid;
    logic [3:0]      rx_pid;
    logic [6:0]      rx_addr;
    logic [3:0]      rx_endp;
    logic            rx_data_valid;
    logic            rx_crc_ok;
    logic            rx_hs_valid;
    logic [N_EP-1:0] ep_stall;
    logic [N_EP-1:0] in_ready;
    logic            in_consume;
    logic [N_EP-1:0] out_space;
    logic            out_commit;
    logic            out_discard;
    logic [3:0]      cur_endp;
    logic            tx_valid;
    logic [3:0]      tx_pid;
    logic            tx_ready;
    logic            tx_done;

    modport slave (
        input  rx_tok_valid, rx_pid, rx_addr, rx_endp, rx_data_valid, rx_crc_ok, rx_hs_valid,
        input  ep_stall, in_ready, out_space, tx_ready, tx_done,
        output in_consume, out_commit, out_discard, cur_endp, tx_valid, tx_pid
    );

    modport master (
        output rx_tok_valid, rx_pid, rx_addr, rx_endp, rx_data_valid, rx_crc_ok, rx_hs_valid,
        output ep_stall, in_ready, out_space, tx_ready, tx_done,
        input  in_consume, out_commit, out_discard, cur_endp, tx_valid, tx_pid
    );
endinterface

// File: rtl/usb_xact_ctrl_toggle_bank.sv
// usb_toggle_bank: per-endpoint DATA0/DATA1 toggles for IN and OUT directions
module usb_toggle_bank #(
    parameter int N_EP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ep,
    input  logic       flip_in,
    input  logic       flip_out,
    input  logic       setup,
    output logic       tog_in,
    output logic       tog_out
);
    logic [N_EP-1:0] tin, tout, oh;

    // endpoints outside the bank select nothing, so they read 0 and never write
    assign oh      = N_EP'(1) << ep;
    assign tog_in  = |(tin & oh);
    assign tog_out = |(tout & oh);

    // SETUP forces both toggles of the endpoint to 1; otherwise flip on request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tin  <= '0;
            tout <= '0;
        end else begin
            tin  <= (tin ^ ({N_EP{flip_in}} & oh)) | ({N_EP{setup}} & oh);
            tout <= (tout ^ ({N_EP{flip_out}} & oh)) | ({N_EP{setup}} & oh);
        end
    end
endmodule

// File: rtl/usb_xact_ctrl.sv
// usb_xact_ctrl: low-speed USB device transaction sequencer (token -> data -> handshake)
// Optional SOF frame capture with USB_SOF_FRAME_EN.
module usb_xact_ctrl
    import usb_xact_ctrl_pkg::*;
#(
    parameter int N_EP    = 2,
    parameter int TIMEOUT = USB_LS_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  dev_addr,
`ifdef USB_SOF_FRAME_EN
    input  logic [10:0] rx_frame,
    output logic [10:0] frame_no,
`endif
    usb_xact_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    xact_state_t     state, state_n;
    pid_t            pid_r, pid_n;
    logic [3:0]      ep_r, sel_ep;
    logic [N_EP-1:0] oh;
    logic [TW-1:0]   timer;
    logic            setup_r, setup_n, acc, load_ep;
    logic            commit_n, discard_n, consume_n;
    logic            flip_in, flip_out, setup_tog, tog_in, tog_out;
    logic            tok, match, rx_is_data, timeout, stall, ready, space;

    // IDLE decisions look at the incoming token's endpoint, later ones at the latched one
    assign sel_ep     = state == IDLE ? bus.rx_endp : ep_r;
    assign oh         = N_EP'(1) << sel_ep;
    assign stall      = |(bus.ep_stall & oh);
    assign ready      = |(bus.in_ready & oh);
    assign space      = |(bus.out_space & oh);
    assign tok        = bus.rx_tok_valid && bus.rx_pid != PID_SOF;
    assign match      = bus.rx_addr == dev_addr && {1'b0, bus.rx_endp} < 5'(N_EP);
    assign rx_is_data = bus.rx_pid == PID_DATA0 || bus.rx_pid == PID_DATA1;
    assign timeout    = timer >= TW'(TIMEOUT);
    assign bus.tx_valid = (state == TX_HS || state == TX_DATA) && !acc;
    assign bus.tx_pid   = pid_r;
    assign bus.cur_endp = ep_r;

    usb_toggle_bank #(.N_EP(N_EP)) u_tog (
        .clk(clk), .reset(reset), .ep(sel_ep),
        .flip_in(flip_in), .flip_out(flip_out), .setup(setup_tog),
        .tog_in(tog_in), .tog_out(tog_out)
    );

    // next state, handshake selection and one-cycle requests
    always_comb begin
        state_n   = state;
        pid_n     = pid_r;
        setup_n   = setup_r;
        load_ep   = 1'b0;
        commit_n  = 1'b0;
        discard_n = 1'b0;
        consume_n = 1'b0;
        flip_in   = 1'b0;
        flip_out  = 1'b0;
        setup_tog = 1'b0;
        case (state)
            IDLE: if (tok && match) begin
                if (bus.rx_pid == PID_OUT || bus.rx_pid == PID_SETUP) begin
                    load_ep = 1'b1;
                    setup_n = bus.rx_pid == PID_SETUP;
                    state_n = RX_DATA;
                end else if (bus.rx_pid == PID_IN) begin
                    load_ep = 1'b1;
                    state_n = stall || !ready ? TX_HS : TX_DATA;
                    pid_n   = stall ? PID_STALL : !ready ? PID_NACK : data_pid(tog_in);
                end
            end
            RX_DATA: if (tok) begin
                state_n = IDLE;
            end else if (bus.rx_data_valid) begin
                if (!bus.rx_crc_ok || !rx_is_data) begin
                    discard_n = 1'b1;
                    state_n   = IDLE;
                end else if (setup_r) begin
                    commit_n  = 1'b1;
                    setup_tog = 1'b1;
                    pid_n     = PID_ACK;
                    state_n   = TX_HS;
                end else begin
                    commit_n  = !stall && space && (bus.rx_pid == PID_DATA1) == tog_out;
                    discard_n = !commit_n;
                    flip_out  = commit_n;
                    pid_n     = stall ? PID_STALL : !space ? PID_NACK : PID_ACK;
                    state_n   = TX_HS;
                end
            end else if (timeout) begin
                state_n = IDLE;
            end
            TX_HS, TX_DATA: if (acc && bus.tx_done) state_n = state == TX_HS ? IDLE : WAIT_ACK;
            WAIT_ACK: if (tok) begin
                state_n = IDLE;
            end else if (bus.rx_hs_valid) begin
                consume_n = bus.rx_pid == PID_ACK;
                flip_in   = consume_n;
                state_n   = IDLE;
            end else if (timeout) begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, latched transaction context, turnaround timer and registered pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pid_r           <= PID_ACK;
            ep_r            <= '0;
            setup_r         <= 1'b0;
            acc             <= 1'b0;
            timer           <= '0;
            bus.out_commit  <= 1'b0;
            bus.out_discard <= 1'b0;
            bus.in_consume  <= 1'b0;
        end else begin
            state           <= state_n;
            pid_r           <= pid_n;
            ep_r            <= load_ep ? bus.rx_endp : ep_r;
            setup_r         <= setup_n;
            acc             <= state_n == state && (acc || (bus.tx_valid && bus.tx_ready));
            timer           <= state_n != state ? '0 : timeout ? timer : timer + 1'b1;
            bus.out_commit  <= commit_n;
            bus.out_discard <= discard_n;
            bus.in_consume  <= consume_n;
        end
    end

`ifdef USB_SOF_FRAME_EN
    // SOF carries no device address and never disturbs the transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_no <= '0;
        else if (bus.rx_tok_valid && bus.rx_pid == PID_SOF) frame_no <= rx_frame;
    end
`endif
endmodule
